// File: rtl/step_clock_controller.sv
// step_clock_controller: CPU clock-enable generator with free-run and debounced manual-step modes
//   clk_in      - system clock
//   reset       - synchronous active-high reset
//   sw0         - asynchronous mode switch (1 = manual step)
//   btnD        - asynchronous step button
//   cpu_ce      - registered one-cycle clock-enable to the control unit
//   manual_mode - debounced sw0 level
//   step_btn    - debounced btnD level
//   step_count  - manual steps issued, wrapping
module step_clock_controller #(
    parameter int RUN_DIV         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_W          = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              sw0,
    input  logic              btnD,
    output logic              cpu_ce,
    output logic              manual_mode,
    output logic              step_btn,
    output logic [STEP_W-1:0] step_count
);
    localparam int DIVW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [1:0] {RUN, MAN_WAIT, MAN_STEP, MAN_RELEASE} state_t;
    state_t            r_state, w_next;
    logic [1:0]        r_s1, r_s2, r_lvl;
    logic [DIVW-1:0]   r_div;
    logic [STEP_W-1:0] r_step;
    logic              r_ce;
    logic              w_mode, w_btn, w_div_wrap, w_ce;
    // index 0 carries sw0, index 1 carries btnD
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {btnD, sw0};
            r_s2 <= r_s1;
        end
    end
    for (genvar g = 0; g < 2; g++) begin : g_db
        logic [DBW-1:0] r_cnt;
        always_ff @(posedge clk_in) begin
            if (reset) begin
                r_cnt    <= '0;
                r_lvl[g] <= 1'b0;
            end else if (r_s2[g] == r_lvl[g]) begin
                r_cnt <= '0;
            end else if (r_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt    <= '0;
                r_lvl[g] <= r_s2[g];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign w_mode     = r_lvl[0];
    assign w_btn      = r_lvl[1];
    assign w_div_wrap = (r_div == DIVW'(RUN_DIV - 1));
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RUN:         w_next = w_mode ? (w_btn ? MAN_RELEASE : MAN_WAIT) : RUN;
            MAN_WAIT:    w_next = !w_mode ? RUN : (w_btn ? MAN_STEP : MAN_WAIT);
            MAN_STEP:    w_next = !w_mode ? RUN : MAN_RELEASE;
            MAN_RELEASE: w_next = !w_mode ? RUN : (w_btn ? MAN_RELEASE : MAN_WAIT);
            default:     w_next = RUN;
        endcase
    end
    // div is held at 0 outside RUN and starts counting on the cycle RUN is entered,
    // so a mode-change cycle can never also produce a free-run pulse
    assign w_ce = (w_next == MAN_STEP) || (w_next == RUN && w_div_wrap);
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= RUN;
            r_div   <= '0;
            r_step  <= '0;
            r_ce    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_div   <= (w_next != RUN || w_div_wrap) ? '0 : r_div + 1'b1;
            r_step  <= (w_next == MAN_STEP) ? r_step + 1'b1 : r_step;
            r_ce    <= w_ce;
        end
    end
    assign cpu_ce      = r_ce;
    assign manual_mode = r_lvl[0];
    assign step_btn    = r_lvl[1];
    assign step_count  = r_step;
endmodule

// File: tb/tb_step_clock_controller.sv
// tb_step_clock_controller: directed self-checking bench for step_clock_controller
module tb_step_clock_controller;
    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       sw0    = 1'b0;
    logic       btnD   = 1'b0;
    logic       cpu_ce, manual_mode, step_btn;
    logic [3:0] step_count;
    int n_tests = 0;
    int n_fail  = 0;

    step_clock_controller #(.RUN_DIV(5), .DEBOUNCE_CYCLES(4), .STEP_W(4)) dut (
        .clk_in(clk_in), .reset(reset), .sw0(sw0), .btnD(btnD),
        .cpu_ce(cpu_ce), .manual_mode(manual_mode), .step_btn(step_btn),
        .step_count(step_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // tick n cycles, counting cpu_ce pulses and the 1-based cycle of the first one
    task automatic run(input int n, output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (cpu_ce) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
    endtask

    initial begin
        int cnt, first, hi, k;
        // 1: reset and free-run
        repeat (3) tick();
        check("rst_ce", cpu_ce, 0);
        check("rst_mode", manual_mode, 0);
        check("rst_btn", step_btn, 0);
        check("rst_count", step_count, 0);
        reset = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check($sformatf("run_ce_c%0d", i), cpu_ce, (i % 5 == 0) ? 1 : 0);
        end
        check("run_count", step_count, 0);
        // 2: bouncing button in manual mode
        sw0 = 1'b1;
        repeat (8) tick();
        check("man_mode_on", manual_mode, 1);
        cnt = 0;
        hi = 0;
        for (int i = 0; i < 24; i++) begin
            btnD = ((i / 2) % 2 == 0);
            tick();
            cnt += cpu_ce;
            hi += step_btn;
        end
        btnD = 1'b0;
        repeat (8) tick();
        check("bounce_ce", cnt, 0);
        check("bounce_btn", hi, 0);
        check("bounce_count", step_count, 0);
        // 3: held press gives exactly one step
        btnD = 1'b1;
        run(40, cnt, first);
        check("press1_cnt", cnt, 1);
        check("press1_lat", first, 7);
        check("press1_count", step_count, 1);
        btnD = 1'b0;
        repeat (10) tick();
        btnD = 1'b1;
        run(10, cnt, first);
        check("press2_cnt", cnt, 1);
        btnD = 1'b0;
        repeat (10) tick();
        check("press2_count", step_count, 2);
        // 4: entering manual with button held, then leaving during release
        sw0 = 1'b0;
        repeat (10) tick();
        check("back_run", manual_mode, 0);
        btnD = 1'b1;
        repeat (10) tick();
        check("held_btn", step_btn, 1);
        sw0 = 1'b1;
        repeat (7) tick();
        check("held_mode", manual_mode, 1);
        run(20, cnt, first);
        check("held_no_ce", cnt, 0);
        check("held_count", step_count, 2);
        btnD = 1'b0;
        repeat (10) tick();
        btnD = 1'b1;
        run(10, cnt, first);
        check("repress_cnt", cnt, 1);
        check("repress_lat", first, 7);
        check("repress_count", step_count, 3);
        sw0 = 1'b0;
        cnt = 0;
        k = 0;
        while (manual_mode && k < 20) begin
            tick();
            cnt += cpu_ce;
            k++;
        end
        check("exit_seen", manual_mode, 0);
        check("exit_no_ce", cnt, 0);
        run(10, cnt, first);
        check("exit_first_ce", first, 5);
        // 5: reset mid-count aborts the pending pulse
        btnD = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (!cpu_ce && k < 10);
        check("sync_ce", cpu_ce, 1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_ce", cpu_ce, 0);
        check("mid_rst_count", step_count, 0);
        reset = 1'b0;
        tick();
        check("old_slot_ce", cpu_ce, 0);
        run(9, cnt, first);
        check("post_rst_first", first + 1, 5);
        check("post_rst_cnt", cnt, 2);
        // 6: seventeen presses wrap the step counter
        sw0 = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 17; i++) begin
            int c1, c2, f;
            btnD = 1'b1;
            run(8, c1, f);
            btnD = 1'b0;
            run(8, c2, f);
            check($sformatf("wrap_ce_%0d", i + 1), c1 + c2, 1);
            check($sformatf("wrap_count_%0d", i + 1), step_count, (i + 1) % 16);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
